// File: rtl/banked_wram_controller.sv
// banked_wram_controller
//   Banked working RAM behind the memory router, with the SVBK bank-select register
//   on the IO register bus. The internal RAM holds NUM_BANKS x 2^BANK_ADDR_W bytes.
//   Window 0xC000-0xCFFF always maps to bank 0. Window 0xD000-0xDFFF maps to the
//   effective bank. Window 0xE000-0xFDFF echoes 0xC000-0xDDFF.
//   Every accepted request is acknowledged exactly READ_LAT cycles later, in request order.
//
// Optional feature (macro WRAM_CLEAR_EN):
//   After reset, the RAM is zero-filled once, one location per cycle.
//   Requests are held off with O_WRAM_BUSY while the fill runs.
//
// Ports:
//   I_CLK, I_RESET_L              clock, asynchronous active-low reset
//   I_IOREG_ADDR/DIN/WE_L/RE_L    IO register bus (SVBK at SVBK_ADDR)
//   O_IOREG_DOUT                  SVBK read data, 8'h00 when not selected
//   I_WRAM_ADDR/DIN/WE_L/RE_L     router request (write wins if both strobes low)
//   O_WRAM_DOUT                   read data, updated on read acks only
//   O_WRAM_ACK                    one-cycle completion pulse per accepted request
//   O_WRAM_BUSY                   requests not accepted while high
//   I_IN_DMG_MODE                 DMG compatibility: bank 1 forced, SVBK writes ignored
//   O_BANK_SEL                    effective bank for the switchable window
module banked_wram_controller #(
   parameter int unsigned NUM_BANKS   = 8,
   parameter int unsigned BANK_ADDR_W = 12,
   parameter int unsigned READ_LAT    = 2,
   parameter logic [15:0] SVBK_ADDR   = 16'hFF70
) (
   input  logic                         I_CLK,
   input  logic                         I_RESET_L,
   input  logic [15:0]                  I_IOREG_ADDR,
   input  logic [7:0]                   I_IOREG_DIN,
   output logic [7:0]                   O_IOREG_DOUT,
   input  logic                         I_IOREG_WE_L,
   input  logic                         I_IOREG_RE_L,
   input  logic [15:0]                  I_WRAM_ADDR,
   input  logic [7:0]                   I_WRAM_DIN,
   output logic [7:0]                   O_WRAM_DOUT,
   input  logic                         I_WRAM_WE_L,
   input  logic                         I_WRAM_RE_L,
   output logic                         O_WRAM_ACK,
   output logic                         O_WRAM_BUSY,
   input  logic                         I_IN_DMG_MODE,
   output logic [$clog2(NUM_BANKS)-1:0] O_BANK_SEL
);

   localparam int unsigned BSW    = $clog2(NUM_BANKS);
   localparam int unsigned PHYS_W = BSW + BANK_ADDR_W;
   localparam int unsigned DEPTH  = NUM_BANKS * (2 ** BANK_ADDR_W);

   // ---------------------------------------------------------------- SVBK register
   logic [BSW-1:0] svbk_q;
   logic [BSW-1:0] eff_bank;
   logic           svbk_we;
   logic           unused_din;

   assign svbk_we    = !I_IOREG_WE_L && (I_IOREG_ADDR == SVBK_ADDR) && !I_IN_DMG_MODE;
   assign unused_din = ^I_IOREG_DIN[7:BSW];

   always_ff @(posedge I_CLK or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         svbk_q <= '0;
      end else if (svbk_we) begin
         svbk_q <= I_IOREG_DIN[BSW-1:0];
      end
   end

   // Bank 0 is never selectable in the switchable window; 0 and DMG mode both mean bank 1.
   always_comb begin
      eff_bank = svbk_q;
      if (I_IN_DMG_MODE || (svbk_q == '0)) begin
         eff_bank = BSW'(1);
      end
   end

   // Unused register bits read back as 1.
   always_comb begin
      O_IOREG_DOUT = 8'h00;
      if (!I_IOREG_RE_L && (I_IOREG_ADDR == SVBK_ADDR)) begin
         O_IOREG_DOUT            = 8'hFF;
         O_IOREG_DOUT[BSW-1:0]   = svbk_q;
      end
   end

   // ---------------------------------------------------------------- address decode
   logic [15:0]       cpu_addr;
   logic [BSW-1:0]    req_bank;
   logic              oor;
   logic [PHYS_W-1:0] phys;

   always_comb begin
      cpu_addr = I_WRAM_ADDR;
      if ((I_WRAM_ADDR >= 16'hE000) && (I_WRAM_ADDR <= 16'hFDFF)) begin
         cpu_addr = I_WRAM_ADDR - 16'h2000;
      end
      req_bank = '0;
      oor      = 1'b0;
      case (cpu_addr[15:12])
         4'hC:    req_bank = '0;
         4'hD:    req_bank = eff_bank;
         default: oor      = 1'b1;
      endcase
      phys = {req_bank, cpu_addr[BANK_ADDR_W-1:0]};
   end

   // ---------------------------------------------------------------- request accept
   logic busy;
   logic acc;
   logic acc_wr;

   assign acc    = (!I_WRAM_WE_L || !I_WRAM_RE_L) && !busy;
   assign acc_wr = acc && !I_WRAM_WE_L;

   // ---------------------------------------------------------------- RAM write port
   logic [7:0]        mem [DEPTH];
   logic              mem_we;
   logic [PHYS_W-1:0] mem_waddr;
   logic [7:0]        mem_wdata;

`ifdef WRAM_CLEAR_EN
   typedef enum logic [1:0] {StIdle, StClear, StDone} clr_state_e;

   clr_state_e        clr_state_q;
   logic [PHYS_W-1:0] clr_addr_q;
   logic              busy_q;

   // busy_q is high exactly while the FSM is in StClear.
   always_ff @(posedge I_CLK or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         clr_state_q <= StIdle;
         clr_addr_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         unique case (clr_state_q)
            StIdle: begin
               clr_state_q <= StClear;
               clr_addr_q  <= '0;
               busy_q      <= 1'b1;
            end
            StClear: begin
               clr_addr_q <= clr_addr_q + PHYS_W'(1);
               if (clr_addr_q == PHYS_W'(DEPTH - 1)) begin
                  clr_state_q <= StDone;
                  busy_q      <= 1'b0;
               end
            end
            StDone: begin
               busy_q <= 1'b0;
            end
            default: begin
               clr_state_q <= StIdle;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      mem_we    = acc_wr && !oor;
      mem_waddr = phys;
      mem_wdata = I_WRAM_DIN;
`ifdef WRAM_CLEAR_EN
      // No request is accepted while clearing, so the port is free.
      if (busy_q) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr_q;
         mem_wdata = 8'h00;
      end
`endif
   end

   always_ff @(posedge I_CLK) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // ---------------------------------------------------------------- response pipeline
   // Read data is captured at accept so later writes cannot disturb an earlier read.
   // Out-of-range reads carry 8'hFF in place of RAM data.
   logic [READ_LAT-1:0] vld_d, vld_q;
   logic [READ_LAT-1:0] rd_d, rd_q;
   logic [7:0]          dat_d [READ_LAT];
   logic [7:0]          dat_q [READ_LAT];
   logic [7:0]          dout_q;

   always_comb begin
      vld_d[0] = acc;
      rd_d[0]  = acc && I_WRAM_WE_L;
      dat_d[0] = oor ? 8'hFF : mem[phys];
      for (int i = 1; i < READ_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         rd_d[i]  = rd_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         vld_q  <= '0;
         rd_q   <= '0;
         dout_q <= 8'hFF;
      end else begin
         vld_q <= vld_d;
         rd_q  <= rd_d;
         if (vld_d[READ_LAT-1] && rd_d[READ_LAT-1]) begin
            dout_q <= dat_d[READ_LAT-1];
         end
      end
   end

   always_ff @(posedge I_CLK) begin
      dat_q <= dat_d;
   end

   assign O_WRAM_ACK  = vld_q[READ_LAT-1];
   assign O_WRAM_DOUT = dout_q;
   assign O_WRAM_BUSY = busy;
   assign O_BANK_SEL  = eff_bank;

endmodule
